// File: rtl/int_div_unit.sv
// Iterative radix-2^M integer divider/remainder with early exit, single-cycle
// special cases, one-entry DIV/REM result reuse, flush and valid/ready handshakes.
module int_div_unit #(
  parameter int N          = 32,
  parameter int M          = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [N-1:0] y,
  output logic         busy
);

  localparam int ITERS = N / M;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] quot, dvd, dvs;
  logic [N:0]   prem;
  logic [CW-1:0] cnt;
  logic         is_rem, q_neg, r_neg, cur_signed;
  logic [N-1:0] cur_a, cur_b;

  logic         reuse_valid, reuse_signed, reuse_rem;
  logic [N-1:0] reuse_a, reuse_b, reuse_q, reuse_r;

  logic         in_signed, in_rem, accept, hit, div_zero, ovf, a_zero;
  logic [N-1:0] abs_a, abs_b, spec_q, spec_r, dvd_init;
  logic [CW-1:0] cnt_init;
  int           lz_groups;

  logic [N:0]   step_r, diff;
  logic [N-1:0] step_a, step_q, fin_q, fin_r;

  function automatic int clz(input logic [N-1:0] v);
    int n;
    n = N;
    for (int i = 0; i < N; i++)
      if (v[i]) n = N - 1 - i;
    return n;
  endfunction

  assign ready_out = !flush && (state == S_IDLE || (state == S_DONE && ready_in));
  assign accept    = valid_in && ready_out;
  assign busy      = (state != S_IDLE);
  assign in_signed = op[0];
  assign in_rem    = op[1];

  // Operand decode: magnitudes, special cases, reuse match and early-exit setup.
  always_comb begin
    abs_a     = (in_signed && a[N-1]) ? -a : a;
    abs_b     = (in_signed && b[N-1]) ? -b : b;
    div_zero  = (b == '0);
    ovf       = in_signed && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
    a_zero    = (a == '0);
    hit       = reuse_valid && (a == reuse_a) && (b == reuse_b) &&
                (in_signed == reuse_signed) && (in_rem != reuse_rem);
    spec_q    = '0;
    spec_r    = '0;
    if (div_zero) begin
      spec_q = '1;
      spec_r = a;
    end else if (ovf) begin
      spec_q = a;
    end
    lz_groups = (EARLY_EXIT != 0) ? clz(abs_a) / M : 0;
    if (lz_groups >= ITERS) lz_groups = ITERS - 1;
    dvd_init  = abs_a << (lz_groups * M);
    cnt_init  = CW'(ITERS - lz_groups);
  end

  // M restoring steps per cycle; the remainder stays below the divisor.
  always_comb begin
    step_r = prem;
    step_a = dvd;
    step_q = quot;
    diff   = '0;
    for (int i = 0; i < M; i++) begin
      step_r = {step_r[N-1:0], step_a[N-1]};
      step_a = step_a << 1;
      diff   = step_r - {1'b0, dvs};
      if (!diff[N]) begin
        step_r = diff;
        step_q = {step_q[N-2:0], 1'b1};
      end else begin
        step_q = {step_q[N-2:0], 1'b0};
      end
    end
    fin_q = q_neg ? -step_q : step_q;
    fin_r = r_neg ? -step_r[N-1:0] : step_r[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      valid_out    <= 1'b0;
      y            <= '0;
      quot         <= '0;
      dvd          <= '0;
      dvs          <= '0;
      prem         <= '0;
      cnt          <= '0;
      is_rem       <= 1'b0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      cur_signed   <= 1'b0;
      cur_a        <= '0;
      cur_b        <= '0;
      reuse_valid  <= 1'b0;
      reuse_signed <= 1'b0;
      reuse_rem    <= 1'b0;
      reuse_a      <= '0;
      reuse_b      <= '0;
      reuse_q      <= '0;
      reuse_r      <= '0;
    end else if (flush) begin
      state       <= S_IDLE;
      valid_out   <= 1'b0;
      reuse_valid <= 1'b0;
    end else if (accept) begin
      cur_a      <= a;
      cur_b      <= b;
      cur_signed <= in_signed;
      is_rem     <= in_rem;
      if (hit) begin
        state     <= S_DONE;
        valid_out <= 1'b1;
        y         <= in_rem ? reuse_r : reuse_q;
        reuse_rem <= in_rem;
      end else if (div_zero || ovf || a_zero) begin
        state        <= S_DONE;
        valid_out    <= 1'b1;
        y            <= in_rem ? spec_r : spec_q;
        reuse_valid  <= 1'b1;
        reuse_a      <= a;
        reuse_b      <= b;
        reuse_signed <= in_signed;
        reuse_rem    <= in_rem;
        reuse_q      <= spec_q;
        reuse_r      <= spec_r;
      end else begin
        state     <= S_CALC;
        valid_out <= 1'b0;
        dvd       <= dvd_init;
        dvs       <= abs_b;
        prem      <= '0;
        quot      <= '0;
        cnt       <= cnt_init;
        q_neg     <= in_signed && (a[N-1] ^ b[N-1]);
        r_neg     <= in_signed && a[N-1];
      end
    end else if (state == S_CALC) begin
      prem <= step_r;
      dvd  <= step_a;
      quot <= step_q;
      cnt  <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state        <= S_DONE;
        valid_out    <= 1'b1;
        y            <= is_rem ? fin_r : fin_q;
        reuse_valid  <= 1'b1;
        reuse_a      <= cur_a;
        reuse_b      <= cur_b;
        reuse_signed <= cur_signed;
        reuse_rem    <= is_rem;
        reuse_q      <= fin_q;
        reuse_r      <= fin_r;
      end
    end else if (state == S_DONE && ready_in) begin
      state     <= S_IDLE;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed vector table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_int_div_unit;

  localparam logic [1:0] UDIV = 2'b00;
  localparam logic [1:0] SDIV = 2'b01;
  localparam logic [1:0] UREM = 2'b10;
  localparam logic [1:0] SREM = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush[2], valid_in[2], ready_in[2];
  logic        ready_out[2], valid_out[2], busy[2];
  logic [1:0]  op[2];
  logic [31:0] a[2], b[2], y[2];

  int checks   = 0;
  int failures = 0;

  // Reference-model reuse entry.
  bit          m_valid, m_signed, m_rem;
  logic [31:0] m_a, m_b;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          off;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  int_div_unit #(.N(32), .M(4), .EARLY_EXIT(1)) dut (
    .clk(clk), .reset(reset), .flush(flush[0]), .valid_in(valid_in[0]),
    .ready_out(ready_out[0]), .op(op[0]), .a(a[0]), .b(b[0]),
    .valid_out(valid_out[0]), .ready_in(ready_in[0]), .y(y[0]), .busy(busy[0])
  );

  int_div_unit #(.N(32), .M(4), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .reset(reset), .flush(flush[1]), .valid_in(valid_in[1]),
    .ready_out(ready_out[1]), .op(op[1]), .a(a[1]), .b(b[1]),
    .valid_out(valid_out[1]), .ready_in(ready_in[1]), .y(y[1]), .busy(busy[1])
  );

  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] z);
    int sx, sz;
    if (z == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (o[0]) begin
      if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
      sx = x;
      sz = z;
      return o[1] ? 32'(sx % sz) : 32'(sx / sz);
    end
    return o[1] ? x % z : x / z;
  endfunction

  // Cycles from accept to result: smallest count of 4-bit groups holding |a|.
  function automatic int refOffset(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] z, input bit hit);
    logic [31:0] mag;
    int n;
    if (hit || z == 0 || x == 0) return 0;
    if (o[0] && x == 32'h8000_0000 && z == 32'hFFFF_FFFF) return 0;
    mag = (o[0] && x[31]) ? -x : x;
    n = 1;
    while (n < 8 && (mag >> (4 * n)) != 0) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] z, output logic [31:0] res, output int off);
    @(negedge clk);
    valid_in[idx] = 1'b1;
    op[idx]       = o;
    a[idx]        = x;
    b[idx]        = z;
    ready_in[idx] = 1'b1;
    #1;
    checkOutput("ready_out before accept", 32'(ready_out[idx]), 32'd1);
    @(posedge clk);
    #1;
    valid_in[idx] = 1'b0;
    off = -1;
    for (int c = 0; c <= 40; c++) begin
      if (valid_out[idx]) begin
        off = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    res = y[idx];
    if (off < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: no valid_out within 40 cycles, required one");
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] res, x, z, exp_y, last_a, last_b;
  logic [1:0]  o;
  int          off, exp_off, cat, seen;
  bit          hit;

  initial begin
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0; valid_in[i] = 1'b0; ready_in[i] = 1'b1;
      op[i] = UDIV; a[i] = '0; b[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset valid_out", 32'(valid_out[0]), 32'd0);
    checkOutput("reset y", y[0], 32'd0);
    checkOutput("reset busy", 32'(busy[0]), 32'd0);
    checkOutput("reset ready_out", 32'(ready_out[0]), 32'd1);
    checkOutput("reset ready_out full", 32'(ready_out[1]), 32'd1);

    vecs[0]  = '{UDIV, 32'd100,        32'd7,          32'd14,         2};
    vecs[1]  = '{SDIV, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1};
    vecs[2]  = '{SREM, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0};
    vecs[3]  = '{UREM, 32'hFFFF_FFF9,  32'd2,          32'd1,          8};
    vecs[4]  = '{UDIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[5]  = '{UREM, 32'd5,          32'd0,          32'd5,          0};
    vecs[6]  = '{SDIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[7]  = '{SREM, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    vecs[8]  = '{SDIV, 32'd0,          32'd5,          32'd0,          0};
    vecs[9]  = '{SREM, 32'd100,        32'hFFFF_FFF9,  32'd2,          2};
    vecs[10] = '{SDIV, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  2};
    vecs[11] = '{UDIV, 32'd1,          32'hFFFF_FFFF,  32'd0,          1};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, vecs[i].op, vecs[i].a, vecs[i].b, res, off);
      checkOutput($sformatf("vec%0d y", i), res, vecs[i].y);
      checkOutput($sformatf("vec%0d latency", i), 32'(off), 32'(vecs[i].off));
    end

    applyStimulus(1, UDIV, 32'd100, 32'd7, res, off);
    checkOutput("full-iter y", res, 32'd14);
    checkOutput("full-iter latency", 32'(off), 32'd8);
    applyStimulus(1, SREM, 32'hFFFF_FF9C, 32'd7, res, off);
    checkOutput("full-iter srem y", res, 32'hFFFF_FFFE);
    checkOutput("full-iter srem latency", 32'(off), 32'd8);

    // Stalled consumer, then back-to-back accept on release.
    @(negedge clk);
    valid_in[0] = 1'b1; op[0] = UDIV; a[0] = 32'hFFFF_FFFF; b[0] = 32'd3; ready_in[0] = 1'b0;
    @(posedge clk);
    #1;
    valid_in[0] = 1'b0;
    off = -1;
    for (int c = 0; c <= 40; c++) begin
      if (valid_out[0]) begin
        off = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("stall latency", 32'(off), 32'd8);
    valid_in[0] = 1'b1; op[0] = UDIV; a[0] = 32'd9; b[0] = 32'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkOutput("stall y", y[0], 32'h5555_5555);
      checkOutput("stall valid_out", 32'(valid_out[0]), 32'd1);
      checkOutput("stall ready_out", 32'(ready_out[0]), 32'd0);
    end
    @(negedge clk);
    ready_in[0] = 1'b1;
    #1;
    checkOutput("release ready_out", 32'(ready_out[0]), 32'd1);
    @(posedge clk);
    #1;
    valid_in[0] = 1'b0;
    checkOutput("b2b calc valid_out", 32'(valid_out[0]), 32'd0);
    checkOutput("b2b calc busy", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b valid_out", 32'(valid_out[0]), 32'd1);
    checkOutput("b2b y", y[0], 32'd3);
    @(posedge clk);
    #1;

    // Flush mid-CALC with a competing valid_in.
    @(negedge clk);
    valid_in[0] = 1'b1; op[0] = UDIV; a[0] = 32'h8000_0001; b[0] = 32'd5;
    @(posedge clk);
    #1;
    valid_in[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1; valid_in[0] = 1'b1; op[0] = UDIV; a[0] = 32'd7; b[0] = 32'd1;
    #1;
    checkOutput("flush ready_out", 32'(ready_out[0]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flush valid_out", 32'(valid_out[0]), 32'd0);
    checkOutput("flush busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    flush[0] = 1'b0; valid_in[0] = 1'b0;
    #1;
    checkOutput("post-flush ready_out", 32'(ready_out[0]), 32'd1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (valid_out[0] || busy[0]) seen++;
    end
    checkOutput("post-flush idle cycles", 32'(seen), 32'd0);
    applyStimulus(0, UREM, 32'h8000_0001, 32'd5, res, off);
    checkOutput("post-flush urem y", res, 32'd4);
    checkOutput("post-flush urem latency", 32'(off), 32'd8);

    // Reset mid-CALC.
    @(negedge clk);
    valid_in[0] = 1'b1; op[0] = UDIV; a[0] = 32'hFFFF_FFFF; b[0] = 32'd7;
    @(posedge clk);
    #1;
    valid_in[0] = 1'b0;
    checkOutput("pre-reset busy", 32'(busy[0]), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset valid_out", 32'(valid_out[0]), 32'd0);
    checkOutput("mid reset busy", 32'(busy[0]), 32'd0);
    checkOutput("mid reset y", y[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (valid_out[0]) seen++;
    end
    checkOutput("aborted op silent", 32'(seen), 32'd0);
    applyStimulus(0, UDIV, 32'd9, 32'd3, res, off);
    checkOutput("post-reset y", res, 32'd3);
    checkOutput("post-reset latency", 32'(off), 32'd1);

    // Randomized ops against the reference model, starting from an empty reuse entry.
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b0;
    m_valid = 1'b0; m_signed = 1'b0; m_rem = 1'b0; m_a = '0; m_b = '0;
    last_a = 32'd1; last_b = 32'd1;
    for (int i = 0; i < 150; i++) begin
      o   = 2'($urandom_range(0, 3));
      cat = $urandom_range(0, 9);
      x   = $urandom;
      z   = $urandom;
      if (cat < 3 || cat == 5) z = $urandom_range(1, 20);
      case (cat)
        0: z = 32'd0;
        1: begin x = 32'h8000_0000; z = 32'hFFFF_FFFF; end
        2: x = 32'd0;
        3, 4: begin x = last_a; z = last_b; end
        5: x = $urandom_range(0, 300);
        default: ;
      endcase
      hit     = m_valid && x == m_a && z == m_b && o[0] == m_signed && o[1] != m_rem;
      exp_y   = refResult(o, x, z);
      exp_off = refOffset(o, x, z, hit);
      applyStimulus(0, o, x, z, res, off);
      checkOutput($sformatf("rand%0d op%0d 0x%08h/0x%08h y", i, o, x, z), res, exp_y);
      checkOutput($sformatf("rand%0d latency", i), 32'(off), 32'(exp_off));
      m_valid = 1'b1; m_a = x; m_b = z; m_signed = o[0]; m_rem = o[1];
      last_a = x; last_b = z;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
